// File: rtl/conn_ctl_requester_if.sv
// Shared types for the connection-control path and the requester's bundled port.
// The master modport is the requester side; slave is the CPU/manager environment.
package conn_ctl_pkg;
    typedef logic [31:0] IPv4;
    typedef logic [15:0] Port;
    typedef logic [7:0]  FlowId;

    typedef enum logic [2:0] {
        cOK,
        cIdWrong,
        cAlreadyOpen,
        cNotOpen,
        cNoResources
    } ErrStatus;

    typedef struct packed {
        logic        enable;
        logic        open;
        logic [31:0] conn_id;
        IPv4         dest_ip;
        Port         dest_port;
        FlowId       client_flow_id;
    } ConnectionControlIf;

    typedef struct packed {
        logic        valid;
        logic [31:0] conn_id;
        ErrStatus    error_status;
    } ConnSetupStatus;
endpackage

interface conn_ctl_requester_if;
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_open;
    logic [31:0]                     cmd_conn_id;
    conn_ctl_pkg::IPv4               cmd_dest_ip;
    conn_ctl_pkg::Port               cmd_dest_port;
    conn_ctl_pkg::FlowId             cmd_client_flow_id;
    logic                            cm_initialized;
    conn_ctl_pkg::ConnectionControlIf c_ctl_out;
    conn_ctl_pkg::ConnSetupStatus    c_ctl_status_in;
    logic                            resp_valid;
    logic                            resp_ready;
    logic [31:0]                     resp_conn_id;
    conn_ctl_pkg::ErrStatus          resp_error;
    logic                            resp_timeout;
    logic [15:0]                     stat_timeouts;
    logic [15:0]                     stat_stray;

    modport master (
        input  cmd_valid, cmd_open, cmd_conn_id, cmd_dest_ip, cmd_dest_port, cmd_client_flow_id,
        input  cm_initialized, c_ctl_status_in, resp_ready,
        output cmd_ready, c_ctl_out, resp_valid, resp_conn_id, resp_error, resp_timeout,
        output stat_timeouts, stat_stray
    );

    modport slave (
        output cmd_valid, cmd_open, cmd_conn_id, cmd_dest_ip, cmd_dest_port, cmd_client_flow_id,
        output cm_initialized, c_ctl_status_in, resp_ready,
        input  cmd_ready, c_ctl_out, resp_valid, resp_conn_id, resp_error, resp_timeout,
        input  stat_timeouts, stat_stray
    );
endinterface

// File: rtl/conn_ctl_requester.sv
// Connection-control requester: queues open/close commands, issues them one at a time to the
// connection manager and returns one response per command (status reply or timeout).
module conn_ctl_requester
    import conn_ctl_pkg::*;
#(
    parameter int NIC_ID          = 0,
    parameter int QUEUE_DEPTH_LOG = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    conn_ctl_requester_if.master bus
);
    localparam int                Depth     = 2 ** QUEUE_DEPTH_LOG;
    localparam int                TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic        open;
        logic [31:0] conn_id;
        IPv4         dest_ip;
        Port         dest_port;
        FlowId       client_flow_id;
    } cmd_t;

    typedef enum logic [1:0] {sIdle, sIssue, sWait, sResp} state_e;

    cmd_t                     fifo_q [Depth];
    logic [QUEUE_DEPTH_LOG:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                     full, empty, push, pop;
    cmd_t                     cmd_in, head;

    state_e             state_q, state_d;
    ConnectionControlIf ctl_q, ctl_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_id_q, resp_id_d;
    ErrStatus           resp_err_q, resp_err_d;
    logic               resp_to_q, resp_to_d;
    logic [15:0]        stat_to_q, stat_to_d, stat_stray_q, stat_stray_d;
    logic               st_match;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[QUEUE_DEPTH_LOG] != rd_ptr_q[QUEUE_DEPTH_LOG]) &&
                    (wr_ptr_q[QUEUE_DEPTH_LOG-1:0] == rd_ptr_q[QUEUE_DEPTH_LOG-1:0]);
    assign push   = bus.cmd_valid && !full;
    assign head   = fifo_q[rd_ptr_q[QUEUE_DEPTH_LOG-1:0]];
    assign cmd_in = '{open: bus.cmd_open, conn_id: bus.cmd_conn_id, dest_ip: bus.cmd_dest_ip,
                      dest_port: bus.cmd_dest_port, client_flow_id: bus.cmd_client_flow_id};

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[QUEUE_DEPTH_LOG-1:0]] <= cmd_in;
    end

    assign st_match = bus.c_ctl_status_in.valid && (bus.c_ctl_status_in.conn_id == ctl_q.conn_id);

    always_comb begin
        state_d      = state_q;
        ctl_d        = ctl_q;
        timer_d      = timer_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        resp_to_d    = resp_to_q;
        stat_to_d    = stat_to_q;
        stat_stray_d = stat_stray_q;
        pop          = 1'b0;
        unique case (state_q)
            sIdle: begin
                if (!empty && bus.cm_initialized) begin
                    pop     = 1'b1;
                    ctl_d   = '{enable: 1'b1, open: head.open, conn_id: head.conn_id,
                                dest_ip: head.dest_ip, dest_port: head.dest_port,
                                client_flow_id: head.client_flow_id};
                    timer_d = '0;
                    state_d = sIssue;
                end
            end
            sIssue: begin
                // Timer counts cycles since the enable cycle.
                ctl_d.enable = 1'b0;
                timer_d      = timer_q + TimerW'(1);
                state_d      = sWait;
            end
            sWait: begin
                if (st_match) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = ctl_q.conn_id;
                    resp_err_d   = bus.c_ctl_status_in.error_status;
                    resp_to_d    = 1'b0;
                    state_d      = sResp;
                end else begin
                    if (bus.c_ctl_status_in.valid && stat_stray_q != 16'hFFFF)
                        stat_stray_d = stat_stray_q + 16'd1;
                    if (timer_q == TimerLast) begin
                        resp_valid_d = 1'b1;
                        resp_id_d    = ctl_q.conn_id;
                        resp_err_d   = cOK;
                        resp_to_d    = 1'b1;
                        if (stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
                        state_d      = sResp;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
            end
            sResp: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    ctl_d        = '0;
                    state_d      = sIdle;
                end
            end
            default: state_d = sIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= sIdle;
            ctl_q        <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= cOK;
            resp_to_q    <= 1'b0;
            stat_to_q    <= '0;
            stat_stray_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            ctl_q        <= ctl_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            resp_to_q    <= resp_to_d;
            stat_to_q    <= stat_to_d;
            stat_stray_q <= stat_stray_d;
        end
    end

    assign bus.cmd_ready     = !full;
    assign bus.c_ctl_out     = ctl_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_conn_id  = resp_id_q;
    assign bus.resp_error    = resp_err_q;
    assign bus.resp_timeout  = resp_to_q;
    assign bus.stat_timeouts = stat_to_q;
    assign bus.stat_stray    = stat_stray_q;
endmodule

// File: tb/tb_conn_ctl_requester.sv
// Randomized bench: a behavioural connection manager (id table, scheduled replies) and a
// response scoreboard predict every request, response, its arrival cycle and the statistics.
module tb_conn_ctl_requester;
    import conn_ctl_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conn_ctl_requester_if bus();

    conn_ctl_requester #(.NIC_ID(0), .QUEUE_DEPTH_LOG(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit          open;
        logic [31:0] id;
        IPv4         ip;
        Port         port;
        FlowId       flow;
    } cmd_t;

    typedef struct {
        logic [31:0] id;
        ErrStatus    err;
        bit          to;
        int          vis;
    } rsp_t;

    cmd_t exp_cmds[$];
    rsp_t exp_rsp[$];
    bit   tbl[16];
    int   checks = 0, failures = 0;
    int   exp_to = 0, exp_stray = 0, en_count = 0, rsp_count = 0;
    logic [31:0] last_id;
    ErrStatus    last_err;
    bit          last_to;
    int   m_dmin = 1, m_dmax = 15, rdy_pct = 100;
    bit   m_stray = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_cmd(input bit op, input logic [31:0] id, input IPv4 ip, input Port pt,
                            input FlowId fl);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_open = op; bus.cmd_conn_id = id;
        bus.cmd_dest_ip = ip; bus.cmd_dest_port = pt; bus.cmd_client_flow_id = fl;
        while (!bus.cmd_ready && n < 200) begin step(1); n++; end
        chk("push_ready", bus.cmd_ready, 1);
        if (bus.cmd_ready) exp_cmds.push_back('{op, id, ip, pt, fl});
        step(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_cmds.size() + exp_rsp.size()) != 0 && n < bound) begin step(1); n++; end
        chk("drain", exp_cmds.size() + exp_rsp.size(), 0);
        step(2);
    endtask

    // Behavioural connection manager: checks each request and schedules its reply.
    initial begin : mgr
        bit busy = 0, abort = 0, match;
        int e = 0, d = 0, sk = -1, lim = 0, last = 0, k;
        ErrStatus err;
        cmd_t c;
        bus.c_ctl_status_in = '0;
        forever begin
            @(posedge clk); #1;
            bus.c_ctl_status_in = '0;
            if (reset && busy) abort = 1;
            if (busy) begin
                k = cyc - e;
                if (!abort && k <= lim) begin
                    chk("en_single", bus.c_ctl_out.enable, 0);
                    chk("hold_id", bus.c_ctl_out.conn_id, c.id);
                    chk("hold_fields", {bus.c_ctl_out.open, bus.c_ctl_out.dest_ip,
                        bus.c_ctl_out.dest_port, bus.c_ctl_out.client_flow_id},
                        {c.open, c.ip, c.port, c.flow});
                end
                if (k == d) bus.c_ctl_status_in = '{valid: 1'b1, conn_id: c.id, error_status: err};
                else if (k == sk) bus.c_ctl_status_in = '{valid: 1'b1, conn_id: c.id ^ 32'hE, error_status: cOK};
                if (k >= last) begin busy = 0; abort = 0; end
            end
            if (bus.c_ctl_out.enable) begin
                en_count++;
                chk("en_outstanding", busy, 0);
                chk("en_spurious", exp_cmds.size() == 0, 0);
                if (exp_cmds.size() != 0) begin
                    c = exp_cmds.pop_front();
                    chk("req_id", bus.c_ctl_out.conn_id, c.id);
                    chk("req_fields", {bus.c_ctl_out.open, bus.c_ctl_out.dest_ip,
                        bus.c_ctl_out.dest_port, bus.c_ctl_out.client_flow_id},
                        {c.open, c.ip, c.port, c.flow});
                    if (c.id >= 16)        err = cIdWrong;
                    else if (c.open)       err = tbl[c.id[3:0]] ? cAlreadyOpen : cOK;
                    else                   err = tbl[c.id[3:0]] ? cOK : cNotOpen;
                    if (c.id < 16 && err == cOK) tbl[c.id[3:0]] = c.open;
                    d     = $urandom_range(m_dmin, m_dmax);
                    match = (d >= 1 && d <= TO - 1);
                    last  = (d == 0) ? TO : d;
                    if (match) begin
                        exp_rsp.push_back('{c.id, err, 1'b0, cyc + d + 1});
                        lim = d;
                    end else begin
                        exp_rsp.push_back('{c.id, cOK, 1'b1, cyc + TO});
                        exp_to++;
                        lim = TO - 1;
                    end
                    sk = -1;
                    if (m_stray && (d == 6 || $urandom_range(0, 1) == 1))
                        sk = match ? ((d >= 2) ? d - 1 : -1) : 5;
                    if (sk > 0) exp_stray++;
                    e = cyc; busy = 1; abort = 0;
                end
            end
        end
    end

    // Response consumer with random back-pressure and scoreboard.
    initial begin : cons
        bit seen = 0;
        rsp_t r;
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.resp_ready = ($urandom_range(0, 99) < rdy_pct);
            if (reset) begin seen = 0; continue; end
            if (bus.resp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", bus.resp_valid, 0);
                end else begin
                    if (!seen) chk("rsp_cycle", cyc, exp_rsp[0].vis);
                    seen = 1;
                    if (bus.resp_ready) begin
                        r = exp_rsp.pop_front();
                        chk("rsp_id", bus.resp_conn_id, r.id);
                        chk("rsp_err", bus.resp_error, r.err);
                        chk("rsp_timeout", bus.resp_timeout, r.to);
                        chk("stat_timeouts", bus.stat_timeouts, exp_to);
                        chk("stat_stray", bus.stat_stray, exp_stray);
                        last_id = bus.resp_conn_id; last_err = bus.resp_error; last_to = bus.resp_timeout;
                        rsp_count++;
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0, c0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_open = 1'b0; bus.cmd_conn_id = '0;
        bus.cmd_dest_ip = '0; bus.cmd_dest_port = '0; bus.cmd_client_flow_id = '0;
        bus.cm_initialized = 1'b0;
        step(3);
        chk("rst_enable", bus.c_ctl_out.enable, 0);
        chk("rst_ctl_id", bus.c_ctl_out.conn_id, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_id", bus.resp_conn_id, 0);
        chk("rst_resp_err", bus.resp_error, cOK);
        chk("rst_resp_to", bus.resp_timeout, 0);
        chk("rst_stats", {bus.stat_timeouts, bus.stat_stray}, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        reset = 1'b0;

        // Basic open, reply 3 cycles after enable.
        bus.cm_initialized = 1'b1; m_dmin = 3; m_dmax = 3;
        push_cmd(1'b1, 32'd5, 32'h0A00_0001, 16'd80, 8'd2);
        drain(100);
        chk("t1_id", last_id, 5);
        chk("t1_err", last_err, cOK);
        chk("t1_to", last_to, 0);

        // Close then open id 5 twice; second open reports already-open.
        m_dmin = 1; m_dmax = 15; rdy_pct = 50;
        n0 = rsp_count;
        push_cmd(1'b0, 32'd5, '0, '0, '0);
        push_cmd(1'b1, 32'd5, 32'h0A00_0002, 16'd443, 8'd3);
        push_cmd(1'b1, 32'd5, 32'h0A00_0003, 16'd8080, 8'd4);
        drain(300);
        chk("t2_count", rsp_count - n0, 3);
        chk("t2_err", last_err, cAlreadyOpen);

        // Manager not initialized: FIFO fills, nothing issued until init rises.
        bus.cm_initialized = 1'b0; c0 = en_count;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(8 + i), 32'($urandom), 16'($urandom), 8'(i));
        chk("t3_full", bus.cmd_ready, 0);
        step(10);
        chk("t3_no_enable", en_count - c0, 0);
        bus.cm_initialized = 1'b1;
        drain(400);
        chk("t3_issued", en_count - c0, 4);

        // Silent manager: timeout response exactly TO cycles after enable.
        rdy_pct = 100; m_dmin = 0; m_dmax = 0;
        push_cmd(1'b1, 32'd12, 32'h0A00_000C, 16'd22, 8'd5);
        drain(100);
        chk("t4_timeout", last_to, 1);
        chk("t4_stat", bus.stat_timeouts, 1);
        m_dmin = 4; m_dmax = 4;
        push_cmd(1'b1, 32'd13, 32'h0A00_000D, 16'd23, 8'd6);
        drain(100);
        chk("t4_next", {last_id, 7'(0), last_to}, {32'd13, 8'd0});

        // Stray reply (id 9) before the real one (id 7).
        m_stray = 1; m_dmin = 6; m_dmax = 6;
        push_cmd(1'b1, 32'd7, 32'h0A00_0007, 16'd77, 8'd7);
        drain(100);
        chk("t5_stray", bus.stat_stray, 1);
        chk("t5_id", last_id, 7);

        // Random traffic: delays span match, last-cycle match, late and silent replies.
        m_dmin = 0; m_dmax = 17; rdy_pct = 60;
        for (int i = 0; i < 40; i++) begin
            push_cmd(1'($urandom), 32'($urandom_range(0, 19)), 32'($urandom),
                     16'($urandom), 8'($urandom));
            step($urandom_range(0, 3));
        end
        drain(3000);
        chk("rnd_stat_to", bus.stat_timeouts, exp_to);
        chk("rnd_stat_stray", bus.stat_stray, exp_stray);

        // Reset while waiting; a queued command and the late reply must both vanish.
        m_stray = 0; m_dmin = 6; m_dmax = 6; rdy_pct = 100;
        c0 = en_count;
        push_cmd(1'b1, 32'd3, 32'h0A00_0003, 16'd33, 8'd8);
        push_cmd(1'b1, 32'd4, 32'h0A00_0004, 16'd44, 8'd9);
        n0 = 0;
        while (en_count == c0 && n0 < 50) begin step(1); n0++; end
        chk("t6_issued", en_count - c0, 1);
        step(1);
        reset = 1'b1;
        step(1);
        chk("t6_enable", bus.c_ctl_out.enable, 0);
        chk("t6_ctl_id", bus.c_ctl_out.conn_id, 0);
        chk("t6_resp_valid", bus.resp_valid, 0);
        chk("t6_stats", {bus.stat_timeouts, bus.stat_stray}, 0);
        exp_cmds.delete(); exp_rsp.delete(); exp_to = 0; exp_stray = 0;
        step(1);
        reset = 1'b0;
        c0 = en_count;
        step(12);
        chk("t6_no_issue", en_count - c0, 0);
        chk("t6_no_resp", bus.resp_valid, 0);
        chk("t6_no_stray", bus.stat_stray, 0);
        chk("t6_cmd_ready", bus.cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
